midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
Polyphonic successor to the single-voice MIDI note decoder. It accepts decoded MIDI events and maintains NUM_VOICES voice slots, each with note, velocity, active flag and sample-period value. Voices are allocated to note-ons, released on note-offs, and stolen oldest-first when all are busy. It sits between the MIDI byte parser and the per-voice sample-playback engines, which read voice_period and voice_active directly.

Parameters:
NUM_VOICES, 4, number of voice slots (2..16)
PERIOD_WIDTH, 24, width of each voice period value in clk_in cycles
AGE_WIDTH, 8, width of per-voice saturating age counter used for stealing

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
status  input  4  MIDI status nibble (8 note-off, 9 note-on, B control change)
data_byte1  input  8  note number or controller number
data_byte2  input  8  velocity or controller value
valid_in  input  1  event valid; accepted only when ready_out=1
ready_out  output  1  high when idle and able to accept an event
voice_active  output  NUM_VOICES  per-voice sounding flag
voice_note  output  NUM_VOICES*7  packed note numbers, voice i at [7i+6:7i]
voice_velocity  output  NUM_VOICES*7  packed velocities
voice_period  output  NUM_VOICES*PERIOD_WIDTH  packed clk_in cycles between samples
update_valid  output  1  one-cycle pulse: voice state changed
update_voice  output  $clog2(NUM_VOICES)  index of voice changed (0 for all-notes-off)
stolen  output  1  one-cycle pulse with update_valid when an active voice was stolen

Behaviour:
- Single clock clk_in; rst_in synchronous, active-high, overrides everything including in-flight events.
- Reset values: ready_out=1, voice_active=0, every voice_note=60, voice_velocity=0, voice_period=746, ages=0, update_valid=0, update_voice=0, stolen=0, FSM=IDLE.
- Classification at accept: NOTE_ON = status 9 and data_byte2!=0; NOTE_OFF = status 8, or status 9 with data_byte2=0; ALL_OFF = status B and data_byte1=123. Any other status, or data_byte1[7]=1 or data_byte2[7]=1 on a note event, is IGNORED.
- Period: P(n) = BASE[n mod 12] >> (n div 12), truncating, zero-extended to PERIOD_WIDTH. BASE = 23889, 22548, 21283, 20088, 18961, 17897, 16892, 15944, 15049, 14205, 13407, 12655. Examples: P(0)=23889, P(60)=746, P(69)=443, P(127)=15.
- FSM: IDLE -> SEARCH -> COMMIT -> IDLE. ready_out=1 only in IDLE. valid_in while busy is dropped, not queued.
- IDLE: on valid_in, latch the event and enter SEARCH, including IGNORED events.
- SEARCH: exactly NUM_VOICES cycles, examining voice 0..N-1 in order. Tracks first active voice with matching note, first inactive voice, and oldest active voice (largest age; ties go to the lowest index).
- COMMIT: one cycle. All writes land on its closing edge. update_valid/update_voice/stolen are high the following cycle, in IDLE.
- Latency: accept edge to update_valid-high cycle = NUM_VOICES+2 cycles. A new event may be accepted in the update_valid cycle.
- NOTE_ON target priority:
  - 1. Matching active voice (retrigger).
  - 2. Lowest free voice.
  - 3. Oldest voice (stolen=1).
- NOTE_ON writes to target: active=1, note, velocity, period. Target age=0. Every other voice age = min(age+1, 2^AGE_WIDTH-1).
- NOTE_OFF: every active voice with a matching note goes active=0. note, velocity and period are retained. update_voice = lowest such index. No match means no update_valid pulse.
- ALL_OFF: all voice_active cleared; update_valid=1, update_voice=0.
- IGNORED: passes through SEARCH/COMMIT with no state change and no pulse.

Test Plan:
- Reset, then idle 10 cycles -> ready_out=1, voice_active=0, all voice_period=746, update_valid never high.
- NUM_VOICES=4: note-on note 60 vel 100 accepted at cycle k -> update_valid high at k+6 only, update_voice=0, voice0 period 746. Then note-on 69 -> voice1, period 443.
- Note-ons 60, 62, 64, 65, then 67 -> voice0 stolen: stolen=1, voice0 note 67, period 498, voices 1-3 unchanged.
- From that state, status 9 note 62 vel 0 -> voice1 inactive with period 665 retained, update_voice=1. Then note-off 100 -> no update_valid.
- Retrigger: note-on 64 vel 50 while voice2 holds 64 -> update_voice=2, velocity 50, stolen=0, no other voice touched. Note-ons 0 and 127 -> periods 23889 and 15.
- CC123 -> all voices inactive, update_voice=0. valid_in pulsed during SEARCH -> ignored. rst_in asserted mid-SEARCH -> next cycle all outputs at reset values and ready_out=1.

Source files
------------

// File: rtl/midi_voice_allocator_if.sv
// Event-in / voice-state-out bundle between the MIDI parser, the allocator and the playback engines.
// slave = allocator side; master = parser/observer side.
interface midi_voice_allocator_if #(
  parameter int NUM_VOICES   = 4,
  parameter int PERIOD_WIDTH = 24
);
  localparam int VOICE_IDX_W = $clog2(NUM_VOICES);

  logic [3:0]                         status;
  logic [7:0]                         data_byte1;
  logic [7:0]                         data_byte2;
  logic                               valid_in;
  logic                               ready_out;
  logic [NUM_VOICES-1:0]              voice_active;
  logic [NUM_VOICES*7-1:0]            voice_note;
  logic [NUM_VOICES*7-1:0]            voice_velocity;
  logic [NUM_VOICES*PERIOD_WIDTH-1:0] voice_period;
  logic                               update_valid;
  logic [VOICE_IDX_W-1:0]             update_voice;
  logic                               stolen;

  modport slave (
    input  status, data_byte1, data_byte2, valid_in,
    output ready_out, voice_active, voice_note, voice_velocity, voice_period,
           update_valid, update_voice, stolen
  );

  modport master (
    output status, data_byte1, data_byte2, valid_in,
    input  ready_out, voice_active, voice_note, voice_velocity, voice_period,
           update_valid, update_voice, stolen
  );
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: note-on/off/all-off into NUM_VOICES slots, oldest-first stealing; update pulse NUM_VOICES+2 cycles after accept.
// Backpressure: ready_out is high only in IDLE; valid_in while busy is dropped, never queued.
module midi_voice_allocator #(
  parameter int NUM_VOICES   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int AGE_WIDTH    = 8
) (
  input logic                   clk_in,
  input logic                   rst_in,
  midi_voice_allocator_if.slave bus
);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
  localparam logic [VIDX_W-1:0]    LAST_IDX = VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} state_t;
  typedef enum logic [1:0] {EV_IGNORE, EV_NOTE_ON, EV_NOTE_OFF, EV_ALL_OFF} ev_kind_t;

  typedef struct packed {
    ev_kind_t   kind;
    logic [6:0] note;
    logic [6:0] vel;
  } event_t;

  state_t                  state_q, state_d;
  event_t                  ev_in, ev_q;
  logic [VIDX_W-1:0]       scan_q;
  logic                    match_found_q, free_found_q;
  logic [VIDX_W-1:0]       match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_WIDTH-1:0]    old_age_q;
  logic [NUM_VOICES-1:0]   active_q;
  logic [6:0]              note_q   [NUM_VOICES];
  logic [6:0]              vel_q    [NUM_VOICES];
  logic [PERIOD_WIDTH-1:0] period_q [NUM_VOICES];
  logic [AGE_WIDTH-1:0]    age_q    [NUM_VOICES];
  logic                    upd_vld_q, stolen_q;
  logic [VIDX_W-1:0]       upd_voice_q;
  logic [VIDX_W-1:0]       tgt;
  logic                    steal;
  logic                    note_ok;
  logic [PERIOD_WIDTH-1:0] new_period;

  function automatic logic [PERIOD_WIDTH-1:0] note_period(input logic [6:0] n);
    logic [14:0] base;
    logic [6:0]  octave;
    octave = n / 7'd12;
    case (n % 7'd12)
      7'd0:    base = 15'd23889;
      7'd1:    base = 15'd22548;
      7'd2:    base = 15'd21283;
      7'd3:    base = 15'd20088;
      7'd4:    base = 15'd18961;
      7'd5:    base = 15'd17897;
      7'd6:    base = 15'd16892;
      7'd7:    base = 15'd15944;
      7'd8:    base = 15'd15049;
      7'd9:    base = 15'd14205;
      7'd10:   base = 15'd13407;
      default: base = 15'd12655;
    endcase
    return PERIOD_WIDTH'(base >> octave);
  endfunction

  // Classification happens on the raw bytes; velocity-0 note-on is a note-off.
  always_comb begin
    ev_in.kind = EV_IGNORE;
    ev_in.note = bus.data_byte1[6:0];
    ev_in.vel  = bus.data_byte2[6:0];
    note_ok    = !bus.data_byte1[7] && !bus.data_byte2[7];
    case (bus.status)
      4'h9:    if (note_ok) ev_in.kind = (bus.data_byte2 == 8'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
      4'h8:    if (note_ok) ev_in.kind = EV_NOTE_OFF;
      4'hB:    if (bus.data_byte1 == 8'd123) ev_in.kind = EV_ALL_OFF;
      default: ev_in.kind = EV_IGNORE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.valid_in) state_d = S_SEARCH;
      S_SEARCH: if (scan_q == LAST_IDX) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tgt   = old_idx_q;
    steal = 1'b1;
    if (match_found_q) begin
      tgt   = match_idx_q;
      steal = 1'b0;
    end else if (free_found_q) begin
      tgt   = free_idx_q;
      steal = 1'b0;
    end
  end

  assign new_period = note_period(ev_q.note);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ev_q          <= '0;
      scan_q        <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      upd_vld_q     <= 1'b0;
      upd_voice_q   <= '0;
      stolen_q      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i]   <= 7'd60;
        vel_q[i]    <= 7'd0;
        period_q[i] <= PERIOD_WIDTH'(746);
        age_q[i]    <= '0;
      end
    end else begin
      upd_vld_q <= 1'b0;
      stolen_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.valid_in) begin
            ev_q          <= ev_in;
            scan_q        <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
          end
        end
        S_SEARCH: begin
          scan_q <= scan_q + 1'b1;
          if (active_q[scan_q] && note_q[scan_q] == ev_q.note && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= scan_q;
          end
          if (!active_q[scan_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_q;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (active_q[scan_q] && age_q[scan_q] > old_age_q) begin
            old_idx_q <= scan_q;
            old_age_q <= age_q[scan_q];
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            case (ev_q.kind)
              EV_NOTE_ON: begin
                if (VIDX_W'(i) == tgt) begin
                  active_q[i] <= 1'b1;
                  note_q[i]   <= ev_q.note;
                  vel_q[i]    <= ev_q.vel;
                  period_q[i] <= new_period;
                  age_q[i]    <= '0;
                end else if (age_q[i] != AGE_MAX) begin
                  age_q[i] <= age_q[i] + 1'b1;
                end
              end
              EV_NOTE_OFF: if (active_q[i] && note_q[i] == ev_q.note) active_q[i] <= 1'b0;
              EV_ALL_OFF:  active_q[i] <= 1'b0;
              default:     ;
            endcase
          end
          case (ev_q.kind)
            EV_NOTE_ON: begin
              upd_vld_q   <= 1'b1;
              upd_voice_q <= tgt;
              stolen_q    <= steal;
            end
            EV_NOTE_OFF: begin
              if (match_found_q) begin
                upd_vld_q   <= 1'b1;
                upd_voice_q <= match_idx_q;
              end
            end
            EV_ALL_OFF: begin
              upd_vld_q   <= 1'b1;
              upd_voice_q <= '0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_out    = (state_q == S_IDLE);
  assign bus.voice_active = active_q;
  assign bus.update_valid = upd_vld_q;
  assign bus.update_voice = upd_voice_q;
  assign bus.stolen       = stolen_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign bus.voice_note[7*g +: 7]                       = note_q[g];
    assign bus.voice_velocity[7*g +: 7]                   = vel_q[g];
    assign bus.voice_period[PERIOD_WIDTH*g +: PERIOD_WIDTH] = period_q[g];
  end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: hand-derived vector table, saturation/busy/reset sequences,
// and random events checked against a slot-level reference model.
module tb_midi_voice_allocator;
  localparam int NV = 4;
  localparam int PW = 24;
  localparam int AW = 8;
  localparam int VW = $clog2(NV);

  typedef struct {
    logic [3:0]    st;
    logic [7:0]    b1;
    logic [7:0]    b2;
    bit            upd;
    int            voice;
    bit            stl;
    logic [NV-1:0] act;
    bit            chk;
    int            period;
    int            vel;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   vectors = 0;
  int   miscompares = 0;

  bit   m_act [NV];
  int   m_note[NV];
  int   m_vel [NV];
  int   m_per [NV];
  int   m_age [NV];
  int   base_tab[12];
  vec_t tbl[$];

  always #5 clk_in = ~clk_in;

  midi_voice_allocator_if #(.NUM_VOICES(NV), .PERIOD_WIDTH(PW)) bus ();

  midi_voice_allocator #(.NUM_VOICES(NV), .PERIOD_WIDTH(PW), .AGE_WIDTH(AW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  function automatic vec_t mk(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2,
                              input bit upd, input int voice, input bit stl, input logic [NV-1:0] act,
                              input bit chk, input int period, input int vel);
    vec_t v;
    v.st = st; v.b1 = b1; v.b2 = b2; v.upd = upd; v.voice = voice; v.stl = stl;
    v.act = act; v.chk = chk; v.period = period; v.vel = vel;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int period_ref(input int n);
    return base_tab[n % 12] >> (n / 12);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 1'b0; m_note[i] = 60; m_vel[i] = 0; m_per[i] = 746; m_age[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2,
                             output bit upd, output int voice, output bit stl);
    int n;
    int tgt;
    bit ok;
    upd = 1'b0; voice = 0; stl = 1'b0; tgt = -1;
    n  = int'(b1[6:0]);
    ok = !b1[7] && !b2[7];
    if (st == 4'h9 && ok && b2 != 8'd0) begin
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_act[i] && m_note[i] == n) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && !m_act[i]) tgt = i;
      if (tgt < 0) begin
        stl = 1'b1;
        tgt = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
      end
      for (int i = 0; i < NV; i++) begin
        if (i == tgt) m_age[i] = 0;
        else          m_age[i] = (m_age[i] + 1 > 255) ? 255 : m_age[i] + 1;
      end
      m_act[tgt] = 1'b1; m_note[tgt] = n; m_vel[tgt] = int'(b2[6:0]); m_per[tgt] = period_ref(n);
      upd = 1'b1; voice = tgt;
    end else if ((st == 4'h8 || st == 4'h9) && ok) begin
      for (int i = 0; i < NV; i++) begin
        if (m_act[i] && m_note[i] == n) begin
          m_act[i] = 1'b0;
          if (!upd) begin upd = 1'b1; voice = i; end
        end
      end
    end else if (st == 4'hB && b1 == 8'd123) begin
      for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
      upd = 1'b1; voice = 0;
    end
  endtask

  task automatic check_state(input string name);
    logic [NV-1:0]    ea;
    logic [NV*7-1:0]  en;
    logic [NV*7-1:0]  ev;
    logic [NV*PW-1:0] ep;
    for (int i = 0; i < NV; i++) begin
      ea[i]          = m_act[i];
      en[7*i +: 7]   = 7'(m_note[i]);
      ev[7*i +: 7]   = 7'(m_vel[i]);
      ep[PW*i +: PW] = PW'(m_per[i]);
    end
    check({name, " voice_active"},   128'(bus.voice_active),   128'(ea));
    check({name, " voice_note"},     128'(bus.voice_note),     128'(en));
    check({name, " voice_velocity"}, 128'(bus.voice_velocity), 128'(ev));
    check({name, " voice_period"},   128'(bus.voice_period),   128'(ep));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // Drives one event at a negedge, follows it for NUM_VOICES+2 cycles and checks pulse timing and state.
  task automatic run_event(input string name, input logic [3:0] st, input logic [7:0] b1,
                           input logic [7:0] b2, input bit poke,
                           output logic up_seen, output logic [VW-1:0] up_voice, output logic up_stl);
    int   waitc;
    bit   e_upd;
    bit   e_stl;
    int   e_voice;
    logic early;
    waitc = 0;
    while (bus.ready_out !== 1'b1 && waitc < 20) begin
      @(negedge clk_in);
      waitc++;
    end
    if (bus.ready_out !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s ready_out timeout: got %b, expected 1", name, bus.ready_out);
    end
    bus.status = st; bus.data_byte1 = b1; bus.data_byte2 = b2; bus.valid_in = 1'b1;
    model_apply(st, b1, b2, e_upd, e_voice, e_stl);
    early = 1'b0;
    for (int c = 1; c <= NV + 2; c++) begin
      @(negedge clk_in);
      if (c == 1) bus.valid_in = 1'b0;
      if (poke && c == 2) begin
        bus.status = 4'h9; bus.data_byte1 = 8'd70; bus.data_byte2 = 8'd70; bus.valid_in = 1'b1;
      end
      if (poke && c == 3) bus.valid_in = 1'b0;
      if (c < NV + 2 && bus.update_valid === 1'b1) early = 1'b1;
    end
    up_seen  = bus.update_valid;
    up_voice = bus.update_voice;
    up_stl   = bus.stolen;
    check({name, " early update_valid"}, 128'(early), 128'(0));
    check({name, " update_valid"}, 128'(up_seen), 128'(e_upd));
    if (e_upd) check({name, " update_voice"}, 128'(up_voice), 128'(e_voice));
    check({name, " stolen"}, 128'(up_stl), 128'(e_stl));
    check_state(name);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_in);
      if (bus.update_valid !== 1'b0) seen = 1'b1;
    end
    check({name, " no update_valid"}, 128'(seen), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          up;
    logic [VW-1:0] uv;
    logic          us;
    logic [3:0]    st;
    logic [7:0]    b1;
    logic [7:0]    b2;
    int            r;

    base_tab = '{23889, 22548, 21283, 20088, 18961, 17897, 16892, 15944, 15049, 14205, 13407, 12655};
    rst_in = 1'b1;
    bus.valid_in = 1'b0; bus.status = 4'h0; bus.data_byte1 = 8'd0; bus.data_byte2 = 8'd0;

    tbl.push_back(mk(4'h9,  8'd60, 8'd100, 1, 0, 0, 4'b0001, 1,   746, 100));
    tbl.push_back(mk(4'h9,  8'd69, 8'd100, 1, 1, 0, 4'b0011, 1,   443, 100));
    tbl.push_back(mk(4'hB, 8'd123,   8'd0, 1, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'h9,  8'd60, 8'd100, 1, 0, 0, 4'b0001, 1,   746, 100));
    tbl.push_back(mk(4'h9,  8'd62, 8'd100, 1, 1, 0, 4'b0011, 1,   665, 100));
    tbl.push_back(mk(4'h9,  8'd64, 8'd100, 1, 2, 0, 4'b0111, 1,   592, 100));
    tbl.push_back(mk(4'h9,  8'd65, 8'd100, 1, 3, 0, 4'b1111, 1,   559, 100));
    tbl.push_back(mk(4'h9,  8'd67,  8'd90, 1, 0, 1, 4'b1111, 1,   498,  90));
    tbl.push_back(mk(4'h9,  8'd62,   8'd0, 1, 1, 0, 4'b1101, 1,   665, 100));
    tbl.push_back(mk(4'h8, 8'd100,   8'd0, 0, 0, 0, 4'b1101, 0,     0,   0));
    tbl.push_back(mk(4'h9,  8'd64,  8'd50, 1, 2, 0, 4'b1101, 1,   592,  50));
    tbl.push_back(mk(4'h9,   8'd0,  8'd10, 1, 1, 0, 4'b1111, 1, 23889,  10));
    tbl.push_back(mk(4'h9, 8'd127,  8'd20, 1, 3, 1, 4'b1111, 1,    15,  20));
    tbl.push_back(mk(4'hB, 8'd123,   8'd0, 1, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'hA,  8'd60, 8'd100, 0, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'h9, 8'd133, 8'd100, 0, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'h9,  8'd60, 8'd200, 0, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'hB,  8'd64,   8'd0, 0, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'h8,  8'd60,   8'd0, 0, 0, 0, 4'b0000, 0,     0,   0));
    tbl.push_back(mk(4'h8,  8'd60, 8'd200, 0, 0, 0, 4'b0000, 0,     0,   0));

    // Reset, then idle
    do_reset();
    watch_quiet("idle", 10);
    check("idle ready_out", 128'(bus.ready_out), 128'(1));
    check("idle update_voice", 128'(bus.update_voice), 128'(0));
    check("idle stolen", 128'(bus.stolen), 128'(0));
    check_state("idle");

    // Hand-derived table
    foreach (tbl[k]) begin
      run_event($sformatf("tbl[%0d]", k), tbl[k].st, tbl[k].b1, tbl[k].b2, 1'b0, up, uv, us);
      check($sformatf("tbl[%0d] exp update_valid", k), 128'(up), 128'(tbl[k].upd));
      if (tbl[k].upd) check($sformatf("tbl[%0d] exp update_voice", k), 128'(uv), 128'(tbl[k].voice));
      check($sformatf("tbl[%0d] exp stolen", k), 128'(us), 128'(tbl[k].stl));
      check($sformatf("tbl[%0d] exp active", k), 128'(bus.voice_active), 128'(tbl[k].act));
      if (tbl[k].chk) begin
        check($sformatf("tbl[%0d] exp period", k), 128'(bus.voice_period[tbl[k].voice*PW +: PW]),
              128'(tbl[k].period));
        check($sformatf("tbl[%0d] exp velocity", k), 128'(bus.voice_velocity[tbl[k].voice*7 +: 7]),
              128'(tbl[k].vel));
      end
    end

    // Age saturation: voices 0..2 all pinned at max, so the tie steals voice 0
    for (int k = 0; k < NV; k++) run_event("sat fill", 4'h9, 8'(10 + k), 8'd40, 1'b0, up, uv, us);
    for (int k = 0; k < 254; k++) run_event("sat retrig", 4'h9, 8'd13, 8'd40, 1'b0, up, uv, us);
    run_event("sat steal", 4'h9, 8'd14, 8'd40, 1'b0, up, uv, us);
    check("sat steal exp voice", 128'(uv), 128'(0));
    check("sat steal exp stolen", 128'(us), 128'(1));

    // valid_in during SEARCH is dropped
    run_event("busy poke", 4'h9, 8'd30, 8'd33, 1'b1, up, uv, us);
    watch_quiet("busy poke after", NV + 3);
    check_state("busy poke after");

    // Random events against the model
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       st = 4'h9;
      else if (r < 8)  st = 4'h8;
      else if (r == 8) st = 4'hB;
      else             st = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) b1 = 8'($urandom_range(0, 255));
      else                            b1 = 8'($urandom_range(56, 66));
      if (st == 4'hB && $urandom_range(0, 1) == 1) b1 = 8'd123;
      if ($urandom_range(0, 7) == 0)       b2 = 8'd0;
      else if ($urandom_range(0, 15) == 0) b2 = 8'($urandom_range(128, 255));
      else                                 b2 = 8'($urandom_range(1, 127));
      run_event($sformatf("rand[%0d]", k), st, b1, b2, $urandom_range(0, 9) == 0, up, uv, us);
    end

    // Reset asserted mid-SEARCH
    run_event("pre-rst a", 4'h9, 8'd40, 8'd11, 1'b0, up, uv, us);
    run_event("pre-rst b", 4'h9, 8'd41, 8'd12, 1'b0, up, uv, us);
    bus.status = 4'h9; bus.data_byte1 = 8'd50; bus.data_byte2 = 8'd99; bus.valid_in = 1'b1;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    model_reset();
    check("mid-rst ready_out", 128'(bus.ready_out), 128'(1));
    check("mid-rst update_valid", 128'(bus.update_valid), 128'(0));
    check("mid-rst update_voice", 128'(bus.update_voice), 128'(0));
    check("mid-rst stolen", 128'(bus.stolen), 128'(0));
    check_state("mid-rst");
    rst_in = 1'b0;
    watch_quiet("mid-rst after", NV + 3);
    check_state("mid-rst after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
